agendador_atributos: RTL
========================

# agendador_atributos

Per-second attribute scheduler for the Tamagotchi core. It owns the `fome`, `sono` and `felicidade` registers and generates the 1 s tick. Once per second it sequences one update pass through a single shared saturating adder: it raises the attribute matching the current activity state and decays the others on their own periods. It sits beside `controlador_principal`, which supplies `estado`, and it drives the attribute outputs and the status flags.

## Interface
- `TICK_DIV`, 100: clock cycles per second (10 ms clock); must be ≥ 8.
- `INC_STEP`, 10: increment per second applied to the attribute of the active state.
- `DEC_STEP`, 1: decrement applied per decay event.
- `DEC_FOME_S`, 3: seconds between `fome` decays.
- `DEC_SONO_S`, 5: seconds between `sono` decays.
- `DEC_FELIC_S`, 4: seconds between `felicidade` decays.
- `VAL_INICIAL`, 100: reset value of all three attributes.
- `CRIT_LIM`, 20: threshold below which an attribute is critical.
- `clk` in 1: clock, one clock domain; everything is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `estado` in 3: activity state: IDLE=000, COMENDO=001, DORMINDO=010, DANDO_AULA=011; other codes behave as IDLE.
- `fome`, `sono`, `felicidade` out 8 each: attribute registers.
- `tick_seg` out 1: one-cycle pulse marking each second.
- `critico` out 3: {felicidade, sono, fome} < `CRIT_LIM`, registered.
- `morto` out 1: sticky; set when all three attributes are 0.

## Operation
- **Reset values:** attributes = `VAL_INICIAL`; `tick_seg`, `critico`, `morto` = 0; prescaler and decay counters = 0; FSM = ESPERA.
- **Prescaler:**
  - Counts 0..`TICK_DIV`-1 and wraps.
  - `tick_seg` is high while count = `TICK_DIV`-1.
- **FSM states:** ESPERA → ATU_FOME → ATU_SONO → ATU_FELIC → AVALIA → ESPERA.
  - ESPERA exits on `tick_seg` and captures `estado` into `estado_q`. The whole pass uses `estado_q`, so `estado` changes mid-pass have no effect.
  - Each ATU state performs one saturating operation on its attribute through the shared adder.
- **Per-attribute rule in its ATU state:**
  - If `estado_q` is the attribute's activity (COMENDO→fome, DORMINDO→sono, DANDO_AULA→felicidade): add `INC_STEP`, saturating at 255, and clear that attribute's decay counter.
  - Otherwise the decay counter advances. When it reaches `DEC_x_S`-1, subtract `DEC_STEP` (saturating at 0) and reload the counter to 0.
- **AVALIA:** registers `critico`, and sets `morto` if fome = sono = felicidade = 0.
- **When `morto` = 1:** passes stop modifying attributes, `tick_seg` keeps running, and only `rst_n` clears `morto`.
- **Arithmetic:** 9-bit intermediate; the result is clamped to [0, 255].

## Timing
- The first `tick_seg` occurs in cycle `TICK_DIV`-1 after `rst_n` deasserts.
- Relative to the tick cycle T:
  - new `fome` is visible at T+2
  - new `sono` at T+3
  - new `felicidade` at T+4
  - `critico` and `morto` at T+5
- Because `TICK_DIV` ≥ 8, a pass never overlaps the next tick.
- Reset asserted mid-pass: all registers return to their reset values immediately (asynchronously). There is no partial update.

## Configuration
- **`AGENDADOR_PAUSA_EN` defined:** adds input port `pausa` (1 bit). While `pausa` = 1:
  - the prescaler and decay counters freeze;
  - `tick_seg` is held at 0;
  - no pass starts; a pass already in progress completes.
- **Not defined:** no `pausa` port exists; behaviour is identical to `pausa` = 0.

## Structure
- **Shared package `tamagotchi_pkg`:** `estado` code constants (IDLE, COMENDO, DORMINDO, DANDO_AULA), the FSM state enum, and the attribute width of 8.
- **Sub-module `somador_saturado`:** combinational 8-bit add/subtract with clamp, instantiated once and muxed by FSM state.

## Test plan
All scenarios use default parameters.
1. **Reset:** `rst_n` low, then high. Attributes = 100, flags = 0. `tick_seg` first pulses at cycle 99.
2. **COMENDO for 3 s:** `fome` goes 100→110→120→130. `sono` = 100, `felicidade` = 100.
3. **COMENDO for 16 s:** `fome` saturates at 255 on the 16th pass and stays at 255 thereafter.
4. **IDLE for 12 s:** `fome` = 96, `sono` = 98, `felicidade` = 97. Each decrement lands at T+2/T+3/T+4 respectively.
5. **`estado` change:** switch COMENDO→DORMINDO at T+2 of a pass. That pass still increments `fome`. The next pass increments `sono` to 110, and the `sono` decay counter is cleared.
6. **Death and reset:** with `VAL_INICIAL`=1 and all `DEC_x_S`=1, IDLE for 1 s:
   - all attributes = 0, `critico` = 111, `morto` = 1 at T+5;
   - switching to COMENDO leaves `fome` at 0;
   - pulsing `rst_n` low mid-pass restores all attributes to 1 and `morto` to 0.

Source files
------------

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the Tamagotchi core: activity codes, scheduler FSM states and
// attribute width.
package tamagotchi_pkg;

  localparam int unsigned AttrW = 8;

  localparam logic [2:0] EstIdle      = 3'b000;
  localparam logic [2:0] EstComendo   = 3'b001;
  localparam logic [2:0] EstDormindo  = 3'b010;
  localparam logic [2:0] EstDandoAula = 3'b011;

  typedef enum logic [2:0] {
    StEspera,
    StAtuFome,
    StAtuSono,
    StAtuFelic,
    StAvalia
  } agendador_state_e;

endpackage

// File: rtl/somador_saturado.sv
// Combinational 8-bit add/subtract with a 9-bit intermediate, clamped to [0, 255].
module somador_saturado
  import tamagotchi_pkg::*;
(
  input  logic [AttrW-1:0] a,
  input  logic [AttrW-1:0] b,
  input  logic             sub,
  output logic [AttrW-1:0] y
);

  logic [AttrW:0] soma;

  always_comb begin
    if (sub) soma = {1'b0, a} - {1'b0, b};
    else     soma = {1'b0, a} + {1'b0, b};
    // Bit 8 flags overflow on add and borrow on subtract.
    if (soma[AttrW]) y = sub ? '0 : '1;
    else             y = soma[AttrW-1:0];
  end

endmodule

// File: rtl/agendador_atributos.sv
// Per-second attribute scheduler: 1 s prescaler plus a four-step update pass through one
// shared saturating adder. Optional AGENDADOR_PAUSA_EN adds a pausa input that freezes time.
module agendador_atributos
  import tamagotchi_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned INC_STEP    = 10,
  parameter int unsigned DEC_STEP    = 1,
  parameter int unsigned DEC_FOME_S  = 3,
  parameter int unsigned DEC_SONO_S  = 5,
  parameter int unsigned DEC_FELIC_S = 4,
  parameter int unsigned VAL_INICIAL = 100,
  parameter int unsigned CRIT_LIM    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       estado,
`ifdef AGENDADOR_PAUSA_EN
  input  logic             pausa,
`endif
  output logic [AttrW-1:0] fome,
  output logic [AttrW-1:0] sono,
  output logic [AttrW-1:0] felicidade,
  output logic             tick_seg,
  output logic [2:0]       critico,
  output logic             morto
);

  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam int unsigned DecW = 16;
  localparam logic [PreW-1:0]  PreMax  = PreW'(TICK_DIV - 1);
  localparam logic [AttrW-1:0] ValIni  = AttrW'(VAL_INICIAL);
  localparam logic [AttrW-1:0] IncStep = AttrW'(INC_STEP);
  localparam logic [AttrW-1:0] DecStep = AttrW'(DEC_STEP);
  localparam logic [AttrW-1:0] CritLim = AttrW'(CRIT_LIM);

  logic pausa_int;
`ifdef AGENDADOR_PAUSA_EN
  assign pausa_int = pausa;
`else
  assign pausa_int = 1'b0;
`endif

  agendador_state_e state_q, state_d;
  logic [2:0]       estado_q, estado_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [AttrW-1:0] fome_q, fome_d, sono_q, sono_d, felic_q, felic_d;
  logic [DecW-1:0]  cnt_fome_q, cnt_fome_d, cnt_sono_q, cnt_sono_d, cnt_felic_q, cnt_felic_d;
  logic [2:0]       critico_q, critico_d;
  logic             morto_q, morto_d;

  // Operand selection for the shared adder, driven by the current ATU state.
  logic [AttrW-1:0] sel_val, soma;
  logic             sel_ativo, cnt_hit, upd_attr, upd_cnt;
  logic [DecW-1:0]  sel_cnt, sel_lim, cnt_prox;

  always_comb begin
    sel_val   = fome_q;
    sel_ativo = 1'b0;
    sel_cnt   = cnt_fome_q;
    sel_lim   = DecW'(DEC_FOME_S - 1);
    case (state_q)
      StAtuFome: begin
        sel_val   = fome_q;
        sel_ativo = (estado_q == EstComendo);
        sel_cnt   = cnt_fome_q;
        sel_lim   = DecW'(DEC_FOME_S - 1);
      end
      StAtuSono: begin
        sel_val   = sono_q;
        sel_ativo = (estado_q == EstDormindo);
        sel_cnt   = cnt_sono_q;
        sel_lim   = DecW'(DEC_SONO_S - 1);
      end
      StAtuFelic: begin
        sel_val   = felic_q;
        sel_ativo = (estado_q == EstDandoAula);
        sel_cnt   = cnt_felic_q;
        sel_lim   = DecW'(DEC_FELIC_S - 1);
      end
      default: ;
    endcase
  end

  assign cnt_hit  = (sel_cnt == sel_lim);
  assign upd_cnt  = !morto_q;
  assign upd_attr = !morto_q && (sel_ativo || cnt_hit);
  assign cnt_prox = (sel_ativo || cnt_hit) ? '0 : sel_cnt + 1'b1;

  somador_saturado u_somador (
    .a  (sel_val),
    .b  (sel_ativo ? IncStep : DecStep),
    .sub(!sel_ativo),
    .y  (soma)
  );

  assign tick_seg = (pre_q == PreMax) && !pausa_int;

  always_comb begin
    state_d     = state_q;
    estado_d    = estado_q;
    pre_d       = pre_q;
    fome_d      = fome_q;
    sono_d      = sono_q;
    felic_d     = felic_q;
    cnt_fome_d  = cnt_fome_q;
    cnt_sono_d  = cnt_sono_q;
    cnt_felic_d = cnt_felic_q;
    critico_d   = critico_q;
    morto_d     = morto_q;

    if (!pausa_int) pre_d = (pre_q == PreMax) ? '0 : pre_q + 1'b1;

    case (state_q)
      StEspera: begin
        if (tick_seg) begin
          state_d  = StAtuFome;
          estado_d = estado;
        end
      end
      StAtuFome: begin
        state_d = StAtuSono;
        if (upd_attr) fome_d = soma;
        if (upd_cnt) cnt_fome_d = cnt_prox;
      end
      StAtuSono: begin
        state_d = StAtuFelic;
        if (upd_attr) sono_d = soma;
        if (upd_cnt) cnt_sono_d = cnt_prox;
      end
      StAtuFelic: begin
        state_d = StAvalia;
        if (upd_attr) felic_d = soma;
        if (upd_cnt) cnt_felic_d = cnt_prox;
      end
      StAvalia: begin
        state_d   = StEspera;
        critico_d = {felic_q < CritLim, sono_q < CritLim, fome_q < CritLim};
        if (fome_q == '0 && sono_q == '0 && felic_q == '0) morto_d = 1'b1;
      end
      default: state_d = StEspera;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEspera;
      estado_q    <= EstIdle;
      pre_q       <= '0;
      fome_q      <= ValIni;
      sono_q      <= ValIni;
      felic_q     <= ValIni;
      cnt_fome_q  <= '0;
      cnt_sono_q  <= '0;
      cnt_felic_q <= '0;
      critico_q   <= '0;
      morto_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      estado_q    <= estado_d;
      pre_q       <= pre_d;
      fome_q      <= fome_d;
      sono_q      <= sono_d;
      felic_q     <= felic_d;
      cnt_fome_q  <= cnt_fome_d;
      cnt_sono_q  <= cnt_sono_d;
      cnt_felic_q <= cnt_felic_d;
      critico_q   <= critico_d;
      morto_q     <= morto_d;
    end
  end

  assign fome       = fome_q;
  assign sono       = sono_q;
  assign felicidade = felic_q;
  assign critico    = critico_q;
  assign morto      = morto_q;

endmodule
